// File: rtl/pps_phase_diff_if.sv
// ----------------------------------------------------------------------------
// pps_phase_diff_if
//   Bundle of the timestamp inputs and result outputs of pps_phase_diff.
//   The master modport is the driver of timestamps and observer of results
//   (the capture stage / a bench); the slave modport is the phase-difference
//   block itself.
//
//   i_ph_en        strobe, i_ph1..i_ph5 valid this cycle
//   i_ph1..i_ph5   30-bit edge timestamps, 1 ns LSB, mod 2^30
//   o_diff_en      strobe, o_diff2..5 / o_stale updated
//   o_diff2..5     signed saturated PPSk-PPS1 in ns
//   o_stale        bit k-1: PPSk timestamp repeated
//   o_avg_en       strobe, o_avg2..5 / o_avg_vld / o_lock updated
//   o_avg2..5      signed block averages in ns
//   o_avg_vld      bit k-2: whole block of channel k valid
//   o_lock         bit k-2: valid and |average| within lock window
//   o_drop         pulse, a strobe arrived while busy and was ignored
// ----------------------------------------------------------------------------
interface pps_phase_diff_if #(
    parameter int OUT_W = 24
);
    logic                    i_ph_en;
    logic [29:0]             i_ph1;
    logic [29:0]             i_ph2;
    logic [29:0]             i_ph3;
    logic [29:0]             i_ph4;
    logic [29:0]             i_ph5;
    logic                    o_diff_en;
    logic signed [OUT_W-1:0] o_diff2;
    logic signed [OUT_W-1:0] o_diff3;
    logic signed [OUT_W-1:0] o_diff4;
    logic signed [OUT_W-1:0] o_diff5;
    logic [4:0]              o_stale;
    logic                    o_avg_en;
    logic signed [OUT_W-1:0] o_avg2;
    logic signed [OUT_W-1:0] o_avg3;
    logic signed [OUT_W-1:0] o_avg4;
    logic signed [OUT_W-1:0] o_avg5;
    logic [3:0]              o_avg_vld;
    logic [3:0]              o_lock;
    logic                    o_drop;

    modport master (
        output i_ph_en, i_ph1, i_ph2, i_ph3, i_ph4, i_ph5,
        input  o_diff_en, o_diff2, o_diff3, o_diff4, o_diff5, o_stale,
        input  o_avg_en, o_avg2, o_avg3, o_avg4, o_avg5, o_avg_vld, o_lock,
        input  o_drop
    );

    modport slave (
        input  i_ph_en, i_ph1, i_ph2, i_ph3, i_ph4, i_ph5,
        output o_diff_en, o_diff2, o_diff3, o_diff4, o_diff5, o_stale,
        output o_avg_en, o_avg2, o_avg3, o_avg4, o_avg5, o_avg_vld, o_lock,
        output o_drop
    );
endinterface

// File: rtl/pps_phase_diff.sv
// ----------------------------------------------------------------------------
// pps_phase_diff
//   50 MHz-domain post-processing of PPS edge timestamps. Each i_ph_en strobe
//   latches five timestamps, computes PPSk-PPS1 (k=2..5) through one shared
//   modular subtractor, saturates to OUT_W bits, flags repeated (stale)
//   timestamps, accumulates valid samples over 2^AVG_LOG2 seconds and
//   publishes block averages with a per-channel lock flag.
//
//   i_lclk        50 MHz clock
//   i_res_50m_n   synchronous active-low reset
//   bus           pps_phase_diff_if.slave (timestamps in, results out)
//
//   Timing: strobe sampled in cycle 0 -> o_diff_en in cycle 6 -> o_avg_en in
//   cycle 7 when a block completes. Strobes while busy raise o_drop.
// ----------------------------------------------------------------------------
module pps_phase_diff #(
    parameter int OUT_W    = 24,
    parameter int AVG_LOG2 = 3,
    parameter int LOCK_WIN = 100
) (
    input  logic            i_lclk,
    input  logic            i_res_50m_n,
    pps_phase_diff_if.slave bus
);

    localparam int ACC_W = OUT_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]        BLOCK_N = CNT_W'(1) << AVG_LOG2;
    localparam logic signed [31:0]      SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
    localparam logic signed [31:0]      SAT_MIN = -(32'sd1 <<< (OUT_W - 1));
    localparam logic signed [OUT_W:0]   WIN_LIM = (OUT_W + 1)'(LOCK_WIN);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_CALC2, S_CALC3, S_CALC4, S_CALC5, S_PUBLISH
    } state_t;

    state_t                  state;
    logic [29:0]             sh_ph   [5];
    logic [29:0]             prev_ph [5];
    logic                    prev_vld;
    logic [4:0]              stale_r;
    logic signed [OUT_W-1:0] diff_r  [3];
    logic signed [ACC_W-1:0] acc     [4];
    logic [3:0]              bad;
    logic [CNT_W-1:0]        cnt;

    // The 30-bit difference is read as two's complement, so timestamps that
    // straddle the 2^30 wrap still give the short signed distance.
    function automatic logic signed [OUT_W-1:0] sat_diff(input logic [29:0] raw);
        logic signed [31:0] v;
        v = {{2{raw[29]}}, raw};
        if (v > SAT_MAX) v = SAT_MAX;
        if (v < SAT_MIN) v = SAT_MIN;
        return v[OUT_W-1:0];
    endfunction

    // Arithmetic shift floors toward -inf; the block sum of 2^AVG_LOG2
    // OUT_W-bit samples always fits back into OUT_W bits after the shift.
    function automatic logic signed [OUT_W-1:0] block_avg(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> AVG_LOG2;
        return s[OUT_W-1:0];
    endfunction

    // One extra bit so that |-(2^(OUT_W-1))| does not overflow.
    function automatic logic in_window(input logic signed [OUT_W-1:0] v);
        logic signed [OUT_W:0] w;
        w = v;
        if (w < 0) w = -w;
        return w <= WIN_LIM;
    endfunction

    // Shared subtractor: the CALC state selects which channel is processed.
    logic [1:0]              ch;
    logic [2:0]              ph_sel;
    logic [29:0]             sub_raw;
    logic signed [OUT_W-1:0] sub_sat;
    logic                    ch_vld;

    always_comb begin
        ch = 2'd0;
        case (state)
            S_CALC3: ch = 2'd1;
            S_CALC4: ch = 2'd2;
            S_CALC5: ch = 2'd3;
            default: ch = 2'd0;
        endcase
        ph_sel  = {1'b0, ch} + 3'd1;
        sub_raw = sh_ph[ph_sel] - sh_ph[0];
        sub_sat = sat_diff(sub_raw);
        ch_vld  = ~stale_r[0] & ~stale_r[ph_sel];
    end

    always_ff @(posedge i_lclk) begin
        if (!i_res_50m_n) begin
            state         <= S_IDLE;
            prev_vld      <= 1'b0;
            stale_r       <= '0;
            bad           <= '0;
            cnt           <= '0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            bus.o_diff_en <= 1'b0;
            bus.o_diff2   <= '0;
            bus.o_diff3   <= '0;
            bus.o_diff4   <= '0;
            bus.o_diff5   <= '0;
            bus.o_stale   <= '0;
            bus.o_avg_en  <= 1'b0;
            bus.o_avg2    <= '0;
            bus.o_avg3    <= '0;
            bus.o_avg4    <= '0;
            bus.o_avg5    <= '0;
            bus.o_avg_vld <= '0;
            bus.o_lock    <= '0;
            bus.o_drop    <= 1'b0;
        end else begin
            bus.o_diff_en <= 1'b0;
            bus.o_avg_en  <= 1'b0;
            bus.o_drop    <= bus.i_ph_en && (state != S_IDLE);

            if (state == S_CALC2 || state == S_CALC3 ||
                state == S_CALC4 || state == S_CALC5) begin
                if (ch != 2'd3) diff_r[ch] <= sub_sat;
                if (ch_vld) acc[ch] <= acc[ch] + ACC_W'(sub_sat);
                else        bad[ch] <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    // Timestamps are only valid alongside the strobe.
                    if (bus.i_ph_en) begin
                        sh_ph[0] <= bus.i_ph1;
                        sh_ph[1] <= bus.i_ph2;
                        sh_ph[2] <= bus.i_ph3;
                        sh_ph[3] <= bus.i_ph4;
                        sh_ph[4] <= bus.i_ph5;
                        state    <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    for (int k = 0; k < 5; k++) begin
                        stale_r[k] <= prev_vld && (sh_ph[k] == prev_ph[k]);
                        prev_ph[k] <= sh_ph[k];
                    end
                    prev_vld <= 1'b1;
                    state    <= S_CALC2;
                end
                S_CALC2: state <= S_CALC3;
                S_CALC3: state <= S_CALC4;
                S_CALC4: state <= S_CALC5;
                S_CALC5: begin
                    // Registered so the results appear during PUBLISH.
                    bus.o_diff2   <= diff_r[0];
                    bus.o_diff3   <= diff_r[1];
                    bus.o_diff4   <= diff_r[2];
                    bus.o_diff5   <= sub_sat;
                    bus.o_stale   <= stale_r;
                    bus.o_diff_en <= 1'b1;
                    if (!stale_r[0]) cnt <= cnt + CNT_W'(1);
                    state <= S_PUBLISH;
                end
                S_PUBLISH: begin
                    if (cnt == BLOCK_N) begin
                        bus.o_avg2    <= block_avg(acc[0]);
                        bus.o_avg3    <= block_avg(acc[1]);
                        bus.o_avg4    <= block_avg(acc[2]);
                        bus.o_avg5    <= block_avg(acc[3]);
                        bus.o_avg_vld <= ~bad;
                        bus.o_lock[0] <= ~bad[0] & in_window(block_avg(acc[0]));
                        bus.o_lock[1] <= ~bad[1] & in_window(block_avg(acc[1]));
                        bus.o_lock[2] <= ~bad[2] & in_window(block_avg(acc[2]));
                        bus.o_lock[3] <= ~bad[3] & in_window(block_avg(acc[3]));
                        bus.o_avg_en  <= 1'b1;
                        for (int i = 0; i < 4; i++) acc[i] <= '0;
                        bad <= '0;
                        cnt <= '0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pps_phase_diff.sv
// ----------------------------------------------------------------------------
// tb_pps_phase_diff
//   Self-checking bench for pps_phase_diff. A behavioural model computes the
//   expected differences, stale flags and block averages with plain integer
//   arithmetic; each scenario task compares DUT outputs against it.
// ----------------------------------------------------------------------------
module tb_pps_phase_diff;
    localparam int     OUT_W    = 24;
    localparam int     AVG_LOG2 = 3;
    localparam int     LOCK_WIN = 100;
    localparam int     BLOCK    = 1 << AVG_LOG2;
    localparam longint SMAX     = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint SMIN     = -(longint'(1) << (OUT_W - 1));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pps_phase_diff_if #(.OUT_W(OUT_W)) bus ();

    pps_phase_diff #(
        .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2), .LOCK_WIN(LOCK_WIN)
    ) dut (
        .i_lclk(clk),
        .i_res_50m_n(rst_n),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [29:0] ph_in [5];

    // reference model state
    logic [29:0] m_prev [5];
    bit          m_prev_vld;
    longint      m_sum [4];
    bit          m_bad [4];
    int          m_cnt;

    // expectations / observations
    longint      exp_diff [4];
    logic [4:0]  exp_stale;
    logic        exp_avg_en;
    longint      exp_avg [4];
    logic [3:0]  exp_vld, exp_lock;
    int          obs_lat;
    longint      obs_diff [4];
    logic [4:0]  obs_stale;
    logic        obs_avg_en;
    longint      obs_avg [4];
    logic [3:0]  obs_vld, obs_lock;

    task automatic model_reset();
        m_prev_vld = 1'b0;
        m_cnt      = 0;
        for (int c = 0; c < 4; c++) begin m_sum[c] = 0; m_bad[c] = 1'b0; end
    endtask

    task automatic model_strobe();
        longint d, a;
        for (int k = 0; k < 5; k++) exp_stale[k] = m_prev_vld && (ph_in[k] == m_prev[k]);
        for (int k = 0; k < 5; k++) m_prev[k] = ph_in[k];
        m_prev_vld = 1'b1;
        for (int c = 0; c < 4; c++) begin
            d = longint'(ph_in[c+1]) - longint'(ph_in[0]);
            if (d >= (longint'(1) << 29)) d = d - (longint'(1) << 30);
            else if (d < -(longint'(1) << 29)) d = d + (longint'(1) << 30);
            if (d > SMAX) d = SMAX;
            if (d < SMIN) d = SMIN;
            exp_diff[c] = d;
            if (!exp_stale[0] && !exp_stale[c+1]) m_sum[c] += d;
            else m_bad[c] = 1'b1;
        end
        if (!exp_stale[0]) m_cnt++;
        exp_avg_en = (m_cnt == BLOCK);
        if (exp_avg_en) begin
            for (int c = 0; c < 4; c++) begin
                if (m_sum[c] >= 0) a = m_sum[c] / BLOCK;
                else a = -((-m_sum[c] + BLOCK - 1) / BLOCK);
                exp_avg[c]  = a;
                exp_vld[c]  = !m_bad[c];
                exp_lock[c] = !m_bad[c] && (a >= -LOCK_WIN) && (a <= LOCK_WIN);
            end
            model_reset_block();
        end
    endtask

    task automatic model_reset_block();
        m_cnt = 0;
        for (int c = 0; c < 4; c++) begin m_sum[c] = 0; m_bad[c] = 1'b0; end
    endtask

    task automatic drive_ph();
        bus.i_ph1 = ph_in[0]; bus.i_ph2 = ph_in[1]; bus.i_ph3 = ph_in[2];
        bus.i_ph4 = ph_in[3]; bus.i_ph5 = ph_in[4];
    endtask

    task automatic capture_diff();
        obs_diff[0] = bus.o_diff2; obs_diff[1] = bus.o_diff3;
        obs_diff[2] = bus.o_diff4; obs_diff[3] = bus.o_diff5;
        obs_stale   = bus.o_stale;
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drive one strobe from ph_in, wait (bounded) for o_diff_en, capture.
    task automatic do_strobe();
        @(posedge clk); #1;
        bus.i_ph_en = 1'b1;
        drive_ph();
        @(posedge clk); #1;
        bus.i_ph_en = 1'b0;
        model_strobe();
        obs_lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (bus.o_diff_en === 1'b1) begin obs_lat = c; break; end
        end
        capture_diff();
        @(posedge clk); #1;
        obs_avg_en = bus.o_avg_en;
        obs_avg[0] = bus.o_avg2; obs_avg[1] = bus.o_avg3;
        obs_avg[2] = bus.o_avg4; obs_avg[3] = bus.o_avg5;
        obs_vld    = bus.o_avg_vld;
        obs_lock   = bus.o_lock;
    endtask

    task automatic test_reset();
        int pulses;
        bus.i_ph_en = 1'b1;
        ph_in[0] = 30'd1; ph_in[1] = 30'd2; ph_in[2] = 30'd3; ph_in[3] = 30'd4; ph_in[4] = 30'd5;
        drive_ph();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.i_ph_en = 1'b0;
        model_reset();
        n_assert++;
        if ({bus.o_diff_en, bus.o_avg_en, bus.o_drop} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes got %b expected 000", {bus.o_diff_en, bus.o_avg_en, bus.o_drop});
        end
        n_assert++;
        if ({bus.o_diff2, bus.o_diff3, bus.o_diff4, bus.o_diff5} !== '0) begin
            n_fail++; $display("FAIL reset_diff got %h expected 0", {bus.o_diff2, bus.o_diff3, bus.o_diff4, bus.o_diff5});
        end
        n_assert++;
        if ({bus.o_avg2, bus.o_avg3, bus.o_avg4, bus.o_avg5, bus.o_stale, bus.o_avg_vld, bus.o_lock} !== '0) begin
            n_fail++; $display("FAIL reset_avg got %h expected 0", {bus.o_avg2, bus.o_avg3, bus.o_avg4, bus.o_avg5, bus.o_stale, bus.o_avg_vld, bus.o_lock});
        end
        pulses = 0;
        repeat (10) begin @(posedge clk); #1; if (bus.o_diff_en === 1'b1) pulses++; end
        n_assert++;
        if (pulses !== 0) begin n_fail++; $display("FAIL reset_strobe_ignored got %0d expected 0", pulses); end
    endtask

    task automatic test_basic();
        ph_in[0] = 30'd1000; ph_in[1] = 30'd1250; ph_in[2] = 30'd900;
        ph_in[3] = 30'd1000; ph_in[4] = 30'h3000_0000;
        do_strobe();
        n_assert++;
        if (obs_lat !== 6) begin n_fail++; $display("FAIL basic_latency got %0d expected 6", obs_lat); end
        n_assert++;
        if (obs_diff[0] !== 250 || obs_diff[1] !== -100 || obs_diff[2] !== 0 || obs_diff[3] !== SMIN) begin
            n_fail++;
            $display("FAIL basic_diff got %0d %0d %0d %0d expected 250 -100 0 %0d",
                     obs_diff[0], obs_diff[1], obs_diff[2], obs_diff[3], SMIN);
        end
        n_assert++;
        if (obs_stale !== exp_stale) begin n_fail++; $display("FAIL basic_stale got %b expected %b", obs_stale, exp_stale); end
    endtask

    task automatic test_wrap();
        ph_in[0] = 30'h3FFF_FFFE; ph_in[1] = 30'h0000_0003; ph_in[2] = 30'h0FFF_FFFE;
        ph_in[3] = 30'h3FFF_FFF0; ph_in[4] = 30'h3FFF_FFFF;
        do_strobe();
        n_assert++;
        if (obs_diff[0] !== 5) begin n_fail++; $display("FAIL wrap_fwd got %0d expected 5", obs_diff[0]); end
        for (int c = 1; c < 4; c++) begin
            n_assert++;
            if (obs_diff[c] !== exp_diff[c]) begin
                n_fail++; $display("FAIL wrap_ch%0d got %0d expected %0d", c + 2, obs_diff[c], exp_diff[c]);
            end
        end
        ph_in[0] = 30'h0000_0003; ph_in[1] = 30'h3FFF_FFFE; ph_in[2] = 30'h0000_0010;
        ph_in[3] = 30'h2000_0000; ph_in[4] = 30'h0000_0004;
        do_strobe();
        n_assert++;
        if (obs_diff[0] !== -5) begin n_fail++; $display("FAIL wrap_rev got %0d expected -5", obs_diff[0]); end
        n_assert++;
        if (obs_diff[2] !== exp_diff[2]) begin n_fail++; $display("FAIL wrap_half got %0d expected %0d", obs_diff[2], exp_diff[2]); end
    endtask

    task automatic test_average();
        logic [29:0] base;
        apply_reset(2);
        for (int i = 0; i < BLOCK; i++) begin
            base = 30'd5000 + 30'(777 * i);
            ph_in[0] = base; ph_in[1] = base + ((i % 2) ? 30'd11 : 30'd10);
            ph_in[2] = base - 30'd3; ph_in[3] = base + 30'd60; ph_in[4] = base + 30'(i);
            do_strobe();
            n_assert++;
            if (obs_avg_en !== exp_avg_en) begin
                n_fail++; $display("FAIL avg_en_%0d got %b expected %b", i, obs_avg_en, exp_avg_en);
            end
        end
        n_assert++;
        if (obs_avg[0] !== 10) begin n_fail++; $display("FAIL avg2 got %0d expected 10", obs_avg[0]); end
        n_assert++;
        if (obs_vld[0] !== 1'b1 || obs_lock[0] !== 1'b1) begin
            n_fail++; $display("FAIL avg_lock0 got vld=%b lock=%b expected 1 1", obs_vld[0], obs_lock[0]);
        end
        for (int c = 1; c < 4; c++) begin
            n_assert++;
            if (obs_avg[c] !== exp_avg[c]) begin
                n_fail++; $display("FAIL avg_ch%0d got %0d expected %0d", c + 2, obs_avg[c], exp_avg[c]);
            end
        end
    endtask

    task automatic test_stale_channel();
        logic [29:0] base;
        apply_reset(2);
        for (int i = 0; i < BLOCK; i++) begin
            base = 30'd10000 * 30'(i + 1);
            ph_in[0] = base; ph_in[1] = base + 30'd20;
            if (i != 3) ph_in[2] = base + 30'd30;
            ph_in[3] = base - 30'd40; ph_in[4] = base + 30'd5;
            do_strobe();
            n_assert++;
            if (obs_stale !== exp_stale) begin
                n_fail++; $display("FAIL stale_ch_%0d got %b expected %b", i, obs_stale, exp_stale);
            end
            if (i == 3) begin
                n_assert++;
                if (obs_stale[2] !== 1'b1) begin n_fail++; $display("FAIL stale_ph3 got %b expected 1", obs_stale[2]); end
            end
        end
        n_assert++;
        if (obs_avg_en !== 1'b1) begin n_fail++; $display("FAIL stale_ch_avg_en got %b expected 1", obs_avg_en); end
        n_assert++;
        if (obs_vld !== 4'b1101 || obs_lock !== 4'b1101) begin
            n_fail++; $display("FAIL stale_ch_vld got vld=%b lock=%b expected 1101 1101", obs_vld, obs_lock);
        end
    endtask

    task automatic test_stale_ref();
        logic [29:0] base;
        apply_reset(2);
        for (int i = 0; i < BLOCK + 1; i++) begin
            base = 30'd300000 + 30'd1000 * 30'(i);
            if (i != 4) ph_in[0] = base;
            ph_in[1] = base + 30'd7; ph_in[2] = base - 30'd7;
            ph_in[3] = base + 30'd1; ph_in[4] = base + 30'd2;
            do_strobe();
            if (i == 4) begin
                n_assert++;
                if (obs_stale !== 5'b00001) begin n_fail++; $display("FAIL stale_ref got %b expected 00001", obs_stale); end
            end
            n_assert++;
            if (obs_avg_en !== (i == BLOCK)) begin
                n_fail++; $display("FAIL stale_ref_avg_en_%0d got %b expected %b", i, obs_avg_en, (i == BLOCK));
            end
        end
        n_assert++;
        if (obs_vld !== exp_vld || obs_lock !== exp_lock) begin
            n_fail++; $display("FAIL stale_ref_vld got %b/%b expected %b/%b", obs_vld, obs_lock, exp_vld, exp_lock);
        end
    endtask

    task automatic test_drop();
        int   pulses, first;
        logic drop4, drop5;
        apply_reset(2);
        ph_in[0] = 30'd2000; ph_in[1] = 30'd2100; ph_in[2] = 30'd1900;
        ph_in[3] = 30'd2003; ph_in[4] = 30'd1990;
        @(posedge clk); #1;
        bus.i_ph_en = 1'b1; drive_ph();
        model_strobe();
        @(posedge clk); #1; bus.i_ph_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.i_ph_en = 1'b1;
        bus.i_ph1 = 30'd9; bus.i_ph2 = 30'd99999; bus.i_ph3 = 30'd5; bus.i_ph4 = 30'd77; bus.i_ph5 = 30'd0;
        @(posedge clk); #1;
        bus.i_ph_en = 1'b0;
        drop4 = bus.o_drop;
        drop5 = 1'b1;
        pulses = 0; first = -1;
        for (int c = 5; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 5) drop5 = bus.o_drop;
            if (bus.o_diff_en === 1'b1) begin
                pulses++;
                if (first < 0) begin first = c; capture_diff(); end
            end
        end
        n_assert++;
        if (drop4 !== 1'b1 || drop5 !== 1'b0) begin n_fail++; $display("FAIL drop_pulse got c4=%b c5=%b expected 1 0", drop4, drop5); end
        n_assert++;
        if (pulses !== 1 || first !== 6) begin n_fail++; $display("FAIL drop_diff_en got %0d pulses at %0d expected 1 at 6", pulses, first); end
        for (int c = 0; c < 4; c++) begin
            n_assert++;
            if (obs_diff[c] !== exp_diff[c]) begin
                n_fail++; $display("FAIL drop_ch%0d got %0d expected %0d", c + 2, obs_diff[c], exp_diff[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        ph_in[0] = 30'd70000; ph_in[1] = 30'd70500; ph_in[2] = 30'd69000;
        ph_in[3] = 30'd70001; ph_in[4] = 30'd71000;
        @(posedge clk); #1;
        bus.i_ph_en = 1'b1; drive_ph();
        @(posedge clk); #1; bus.i_ph_en = 1'b0;
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        model_reset();
        pulses = 0;
        repeat (15) begin @(posedge clk); #1; if (bus.o_diff_en === 1'b1 || bus.o_avg_en === 1'b1) pulses++; end
        n_assert++;
        if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_strobes got %0d expected 0", pulses); end
        n_assert++;
        if ({bus.o_diff2, bus.o_diff3, bus.o_diff4, bus.o_diff5, bus.o_stale} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs got %h expected 0", {bus.o_diff2, bus.o_diff3, bus.o_diff4, bus.o_diff5, bus.o_stale});
        end
    endtask

    task automatic test_random();
        int off, mode;
        apply_reset(2);
        for (int i = 0; i < 40; i++) begin
            if (i == 0 || $urandom_range(0, 9) != 0) ph_in[0] = 30'($urandom);
            for (int k = 1; k < 5; k++) begin
                if (i == 0 || $urandom_range(0, 9) != 0) begin
                    mode = int'($urandom_range(0, 5));
                    if (mode <= 3)      off = int'($urandom_range(0, 300)) - 150;
                    else if (mode == 4) off = int'($urandom_range(0, 40000)) - 20000;
                    else                off = int'($urandom);
                    ph_in[k] = ph_in[0] + 30'(off);
                end
            end
            do_strobe();
            n_assert++;
            if (obs_lat !== 6) begin n_fail++; $display("FAIL rnd_lat_%0d got %0d expected 6", i, obs_lat); end
            for (int c = 0; c < 4; c++) begin
                n_assert++;
                if (obs_diff[c] !== exp_diff[c]) begin
                    n_fail++; $display("FAIL rnd_diff_%0d_ch%0d got %0d expected %0d", i, c + 2, obs_diff[c], exp_diff[c]);
                end
            end
            n_assert++;
            if (obs_stale !== exp_stale || obs_avg_en !== exp_avg_en) begin
                n_fail++; $display("FAIL rnd_flags_%0d got %b/%b expected %b/%b", i, obs_stale, obs_avg_en, exp_stale, exp_avg_en);
            end
            if (exp_avg_en) begin
                for (int c = 0; c < 4; c++) begin
                    n_assert++;
                    if (obs_avg[c] !== exp_avg[c]) begin
                        n_fail++; $display("FAIL rnd_avg_%0d_ch%0d got %0d expected %0d", i, c + 2, obs_avg[c], exp_avg[c]);
                    end
                end
                n_assert++;
                if (obs_vld !== exp_vld || obs_lock !== exp_lock) begin
                    n_fail++; $display("FAIL rnd_vld_%0d got %b/%b expected %b/%b", i, obs_vld, obs_lock, exp_vld, exp_lock);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_ph_en = 1'b0;
        bus.i_ph1 = '0; bus.i_ph2 = '0; bus.i_ph3 = '0; bus.i_ph4 = '0; bus.i_ph5 = '0;
        model_reset();
        test_reset();
        test_basic();
        test_wrap();
        test_average();
        test_stale_channel();
        test_stale_ref();
        test_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
